// File: rtl/pipeline_stall_controller.sv
// pipeline_stall_controller: applies load-use stalls, taken-branch squashes and
// data-memory freezes to the PC, IF/ID and ID/EX registers. Outputs are Mealy.
// Optional performance counters (StallCount, FlushCount) are built only when
// the macro PIPE_PERF_CNT_EN is defined.
module pipeline_stall_controller #(
  parameter int unsigned FLUSH_SLOTS = 1,
  parameter int unsigned CNT_WIDTH   = 16
) (
  input  logic                 Clk,
  input  logic                 Reset_n,
  input  logic                 StallReq,
  input  logic                 BranchTaken,
  input  logic                 MemBusy,
  output logic                 PCWrite,
  output logic                 IF_ID_Write,
  output logic                 IF_ID_Flush,
  output logic                 ID_EX_Bubble,
  output logic                 PipeFreeze
`ifdef PIPE_PERF_CNT_EN
  ,
  output logic [CNT_WIDTH-1:0] StallCount,
  output logic [CNT_WIDTH-1:0] FlushCount
`endif
);

  localparam int unsigned SLOT_W = 3;

  // Reject unsupported configurations at elaboration time.
  if (FLUSH_SLOTS < 1 || FLUSH_SLOTS > 7) begin : g_bad_flush_slots
    $error("FLUSH_SLOTS must be in 1..7");
  end
  if (CNT_WIDTH < 1) begin : g_bad_cnt_width
    $error("CNT_WIDTH must be at least 1");
  end

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    FLUSH    = 2'd1,
    MEM_WAIT = 2'd2
  } state_t;

  state_t              state, state_next, eff_state;
  logic [SLOT_W-1:0]   slots_left, slots_next;
  logic                resume_flush, resume_next;

  // State, squash-slot counter and resume flag.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state        <= RUN;
      slots_left   <= '0;
      resume_flush <= 1'b0;
    end else begin
      state        <= state_next;
      slots_left   <= slots_next;
      resume_flush <= resume_next;
    end
  end

  // Next state and Mealy outputs; a finished freeze is evaluated as its return state.
  always_comb begin
    state_next   = state;
    slots_next   = slots_left;
    resume_next  = resume_flush;
    PCWrite      = 1'b1;
    IF_ID_Write  = 1'b1;
    IF_ID_Flush  = 1'b0;
    ID_EX_Bubble = 1'b0;
    PipeFreeze   = 1'b0;

    eff_state = state;
    if (state == MEM_WAIT && !MemBusy) begin
      eff_state = (resume_flush && slots_left != '0) ? FLUSH : RUN;
    end

    case (eff_state)
      RUN: begin
        resume_next = 1'b0;
        state_next  = RUN;
        if (MemBusy) begin
          PCWrite     = 1'b0;
          IF_ID_Write = 1'b0;
          PipeFreeze  = 1'b1;
          state_next  = MEM_WAIT;
        end else if (StallReq) begin
          // Branch operands are not valid yet, so a concurrent branch is ignored.
          PCWrite      = 1'b0;
          IF_ID_Write  = 1'b0;
          ID_EX_Bubble = 1'b1;
        end else if (BranchTaken) begin
          IF_ID_Flush = 1'b1;
          if (FLUSH_SLOTS > 1) begin
            state_next = FLUSH;
            slots_next = SLOT_W'(FLUSH_SLOTS - 1);
          end
        end
      end
      FLUSH: begin
        if (MemBusy) begin
          PCWrite     = 1'b0;
          IF_ID_Write = 1'b0;
          PipeFreeze  = 1'b1;
          resume_next = 1'b1;
          state_next  = MEM_WAIT;
        end else begin
          IF_ID_Flush = 1'b1;
          resume_next = 1'b0;
          if (slots_left > SLOT_W'(1)) begin
            slots_next = slots_left - SLOT_W'(1);
            state_next = FLUSH;
          end else begin
            slots_next = '0;
            state_next = RUN;
          end
        end
      end
      default: begin
        // MEM_WAIT with the memory still busy.
        PCWrite     = 1'b0;
        IF_ID_Write = 1'b0;
        PipeFreeze  = 1'b1;
        state_next  = MEM_WAIT;
      end
    endcase

    // Reset forces a safe pipeline immediately, independent of the clock.
    if (!Reset_n) begin
      PCWrite      = 1'b0;
      IF_ID_Write  = 1'b0;
      IF_ID_Flush  = 1'b1;
      ID_EX_Bubble = 1'b1;
      PipeFreeze   = 1'b0;
    end
  end

`ifdef PIPE_PERF_CNT_EN
  // Saturating counts of bubble cycles and squashed fetch slots.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      StallCount <= '0;
      FlushCount <= '0;
    end else begin
      if (ID_EX_Bubble && StallCount != '1) StallCount <= StallCount + CNT_WIDTH'(1);
      if (IF_ID_Flush && FlushCount != '1) FlushCount <= FlushCount + CNT_WIDTH'(1);
    end
  end
`endif

endmodule

// File: doc/pipeline_stall_controller.md
# pipeline_stall_controller

Applies the pipeline's hazard responses: it consumes the combinational load-use/branch-operand stall request from the hazard detection logic, the taken-branch redirect from ID, and the data-memory busy flag, and drives the write enables, flushes and bubbles of PC, IF/ID and ID/EX. It tracks multi-cycle branch-squash windows and memory freezes, and resumes an interrupted squash window afterwards. It sits beside the hazard detection unit in the ID stage, and its outputs fan out to the PC and the pipeline registers.

## Interface
- `FLUSH_SLOTS`, default 1: number of wrong-path fetch slots squashed after a taken branch, range 1..7.
- `CNT_WIDTH`, default 16: width of the performance counters.
- `Clk`  in  1  rising-edge clock.
- `Reset_n`  in  1  asynchronous, active-low reset.
- `StallReq`  in  1  stall request from the hazard detection unit; level-sensitive, combinational, same cycle.
- `BranchTaken`  in  1  branch or jump resolved taken in ID this cycle.
- `MemBusy`  in  1  data memory cannot complete this cycle.
- `PCWrite`  out  1  PC update enable.
- `IF_ID_Write`  out  1  IF/ID load enable.
- `IF_ID_Flush`  out  1  IF/ID loads a NOP at the next edge.
- `ID_EX_Bubble`  out  1  ID/EX loads all-zero control at the next edge.
- `PipeFreeze`  out  1  hold the ID/EX, EX/MEM and MEM/WB registers.
- `StallCount`  out  CNT_WIDTH  load-use stall cycles; only with the macro.
- `FlushCount`  out  CNT_WIDTH  squashed slots; only with the macro.

## Operation
- **States:** RUN, FLUSH, MEM_WAIT. There is a 3-bit `slots_left` register and a 1-bit `resume_flush` register.
- **Output mode:** outputs are Mealy (state plus current inputs), so each response takes effect at the edge ending the current cycle.
- **Priority:** MemBusy > StallReq > BranchTaken.
- **RUN, MemBusy=1:**
  - PCWrite=0, IF_ID_Write=0, PipeFreeze=1, IF_ID_Flush=0, ID_EX_Bubble=0.
  - Next state MEM_WAIT, resume_flush=0.
- **RUN, StallReq=1 (MemBusy=0):**
  - PCWrite=0, IF_ID_Write=0, ID_EX_Bubble=1, IF_ID_Flush=0.
  - BranchTaken is ignored, because the branch operands are not yet valid. State stays RUN.
- **RUN, BranchTaken=1 only:**
  - PCWrite=1, IF_ID_Write=1, IF_ID_Flush=1.
  - If FLUSH_SLOTS>1, go to FLUSH with slots_left=FLUSH_SLOTS-1. Otherwise stay in RUN.
- **RUN, idle:** PCWrite=1, IF_ID_Write=1, all other outputs 0.
- **FLUSH, MemBusy=0:**
  - PCWrite=1, IF_ID_Write=1, IF_ID_Flush=1. StallReq and BranchTaken are ignored, because the ID stage holds a squashed slot.
  - slots_left decrements. When it reaches 0, go to RUN.
- **FLUSH, MemBusy=1:** freeze outputs as in RUN. Go to MEM_WAIT with resume_flush=1; slots_left is held.
- **MEM_WAIT, MemBusy=1:** freeze outputs.
- **MEM_WAIT, MemBusy=0:**
  - Outputs are evaluated as in the return state during the same cycle.
  - The return state is FLUSH if resume_flush=1 and slots_left!=0, otherwise RUN.
- **Simultaneous MemBusy and BranchTaken:** the branch is not accepted. ID re-presents it after the freeze.
- **Reset asserted (any time, mid-FLUSH included):**
  - State RUN, slots_left=0, resume_flush=0, counters 0.
  - Outputs are forced to PCWrite=0, IF_ID_Write=0, IF_ID_Flush=1, ID_EX_Bubble=1, PipeFreeze=0.

## Timing
- Latency: zero cycles from input to output, one edge from input to state.
- After Reset_n rises, the first edge performs a normal RUN update; PC advances at that edge if the inputs are idle.
- A StallReq held high for N cycles gives exactly N bubbles and holds the PC for N cycles. There is no internal timeout.
- A taken branch in RUN produces exactly FLUSH_SLOTS cycles with IF_ID_Flush=1, not counting freeze cycles.
- slots_left never underflows or wraps. A parameter FLUSH_SLOTS outside 1..7 is a compile-time error.

## Configuration
- `PIPE_PERF_CNT_EN` defined:
  - StallCount increments each cycle in which ID_EX_Bubble=1 and reset is not asserted.
  - FlushCount increments each cycle in which IF_ID_Flush=1 and reset is not asserted.
  - Both counters saturate at all-ones.
- Undefined: both count ports and their registers are absent.

## Test plan
- **Idle pipeline:** release reset with all inputs 0 → PCWrite=1 and IF_ID_Write=1 every cycle, all other outputs 0.
- **Load-use stall:** StallReq=1 for 2 cycles in RUN → 2 cycles of PCWrite=0 with ID_EX_Bubble=1, then normal; with the macro, StallCount=2.
- **Branch squash:** FLUSH_SLOTS=3, BranchTaken pulse → IF_ID_Flush=1 for 3 consecutive cycles. A StallReq during cycles 2–3 is ignored. With the macro, FlushCount=3.
- **Freeze mid-squash:** FLUSH_SLOTS=3, MemBusy=1 for 4 cycles starting in the 2nd flush cycle → PipeFreeze=1 for those 4 cycles, then 2 more flush cycles, then RUN.
- **Priority:** StallReq, BranchTaken and MemBusy all 1 → freeze only. Then MemBusy=0 with StallReq=1 and BranchTaken=1 → bubble only, no flush.
- **Reset mid-FLUSH:** assert Reset_n=0 → within the same cycle IF_ID_Flush=1, ID_EX_Bubble=1, PCWrite=0. Release → RUN with the counters at 0.
